vector_issue_queue: RTL and testbench

Scalar-side issue buffer that feeds the vector unit. Accepts decoded vector instructions (`to_vector`) from the scalar pipeline and presents them in order on a `valid`/`pop` interface. The vector pipeline consumes the head entry by asserting `pop`. The block absorbs vector-unit back-pressure, stalls scalar issue when full, and discards all buffered instructions on a pipeline flush.

---
 rtl/vector_issue_queue_pkg.sv | 24 ++
 rtl/vector_issue_queue.sv | 98 +++++++++
 tb/tb_vector_issue_queue.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/vector_issue_queue_pkg.sv
// Shared vector-side types: the to_vector instruction format and the system default
// issue-queue depth.
package vector_issue_queue_pkg;

    localparam int unsigned VIQ_DEPTH = 4;

    typedef enum logic [1:0] {
        VecAlu,
        VecMul,
        VecLoad,
        VecStore
    } vec_class_e;

    typedef struct packed {
        vec_class_e  op_class;
        logic [5:0]  funct;
        logic [4:0]  vd;
        logic [4:0]  vs1;
        logic [4:0]  vs2;
        logic        vm;
        logic [31:0] scalar_op;
    } to_vector;

endpackage

// File: rtl/vector_issue_queue.sv
// In-order issue buffer between the scalar pipeline and the vector unit.
// Define VIQ_BYPASS_EN to present a push on the output in the same cycle when empty.
module vector_issue_queue
    import vector_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = VIQ_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_valid,
    input  to_vector               push_instr,
    output logic                   push_ready,
    input  logic                   flush,
    output logic                   valid_out,
    output to_vector               instr_out,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    to_vector        mem [DEPTH];
    logic [PtrW-1:0] wp_q, wp_d;
    logic [PtrW-1:0] rp_q, rp_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic empty;
    logic bypass_take;
    logic push_fire;
    logic pop_fire;

    assign empty      = (cnt_q == '0);
    // No pass-through when full keeps push_ready off any path from pop.
    assign push_ready = (cnt_q < Full);
    assign occupancy  = cnt_q;

`ifdef VIQ_BYPASS_EN
    logic bypass;

    assign bypass      = empty && push_valid && !flush;
    // Consumed straight through: nothing is written and no pointer moves.
    assign bypass_take = bypass && pop;
    assign valid_out   = !empty || bypass;
    assign instr_out   = empty ? push_instr : mem[rp_q];
`else
    assign bypass_take = 1'b0;
    assign valid_out   = !empty;
    assign instr_out   = mem[rp_q];
`endif

    assign push_fire = push_valid && push_ready && !flush && !bypass_take;
    assign pop_fire  = pop && valid_out && !flush && !bypass_take;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_fire) begin
                wp_d = wp_q + PtrW'(1);
            end
            if (pop_fire) begin
                rp_d = rp_q + PtrW'(1);
            end
            case ({push_fire, pop_fire})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wp_q] <= push_instr;
        end
    end

endmodule

// File: tb/tb_vector_issue_queue.sv
// Randomised scoreboard bench for vector_issue_queue; a queue-based model supplies
// expected per-cycle status and the expected output instruction stream.
module tb_vector_issue_queue;
    import vector_issue_queue_pkg::*;

    localparam int unsigned DEPTH = VIQ_DEPTH;
    localparam int unsigned OccW  = $clog2(DEPTH) + 1;
`ifdef VIQ_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    typedef struct {
        logic [OccW-1:0] occ;
        logic            ready;
        logic            valid;
    } cyc_exp_t;

    logic            clk;
    logic            rst;
    logic            push_valid;
    to_vector        push_instr;
    logic            push_ready;
    logic            flush;
    logic            valid_out;
    to_vector        instr_out;
    logic            pop;
    logic [OccW-1:0] occupancy;

    cyc_exp_t cyc_q[$];
    to_vector sb[$];
    int       model_cnt;
    int       n_cmp;
    int       n_fail;

    vector_issue_queue #(
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push_valid(push_valid),
        .push_instr(push_instr),
        .push_ready(push_ready),
        .flush     (flush),
        .valid_out (valid_out),
        .instr_out (instr_out),
        .pop       (pop),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic to_vector rand_instr();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return to_vector'(r[$bits(to_vector)-1:0]);
    endfunction

    // One clock cycle of stimulus; records what the queue must show this cycle and
    // appends accepted instructions to the expected output stream.
    task automatic step(input logic pv, input to_vector ins, input logic pp, input logic fl);
        cyc_exp_t e;
        bit       push_ok;
        bit       pop_ok;
        @(posedge clk);
        #2;
        push_valid = pv;
        push_instr = ins;
        pop        = pp;
        flush      = fl;
        e.occ   = OccW'(model_cnt);
        e.ready = (model_cnt < int'(DEPTH));
        e.valid = (model_cnt != 0) || (Bypass && pv && !fl);
        cyc_q.push_back(e);
        if (fl) begin
            sb.delete();
            model_cnt = 0;
        end else begin
            push_ok = pv && (model_cnt < int'(DEPTH));
            pop_ok  = pp && e.valid;
            if (push_ok) sb.push_back(ins);
            model_cnt = model_cnt + int'(push_ok) - int'(pop_ok);
        end
    endtask

    task automatic idle(input logic pp);
        step(1'b0, rand_instr(), pp, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i <= int'(DEPTH) && model_cnt != 0; i++) idle(1'b1);
    endtask

    // Monitor: compares status every stimulated cycle and the head on every pop.
    initial begin : monitor
        cyc_exp_t e;
        to_vector exp_i;
        forever begin
            @(posedge clk);
            #7;
            if (cyc_q.size() != 0) begin
                e = cyc_q.pop_front();
                check("occupancy", 64'(occupancy), 64'(e.occ));
                check("push_ready", 64'(push_ready), 64'(e.ready));
                check("valid_out", 64'(valid_out), 64'(e.valid));
                if (valid_out && pop && !flush) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL instr_out: popped %0h but none expected at %0t",
                                 instr_out, $time);
                    end else begin
                        exp_i = sb.pop_front();
                        check("instr_out", 64'(instr_out), 64'(exp_i));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int r;
        n_cmp      = 0;
        n_fail     = 0;
        model_cnt  = 0;
        rst        = 1'b0;
        push_valid = 1'b0;
        push_instr = '0;
        pop        = 1'b0;
        flush      = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset_valid", 64'(valid_out), 64'(0));
        check("reset_ready", 64'(push_ready), 64'(1));
        check("reset_occ", 64'(occupancy), 64'(0));
        @(posedge clk);
        #2 rst = 1'b0;

        // Pop on empty is ignored.
        repeat (3) idle(1'b1);

        // Fill, overflow attempt, then drain in order.
        repeat (DEPTH + 1) step(1'b1, rand_instr(), 1'b0, 1'b0);
        repeat (DEPTH) idle(1'b1);
        idle(1'b0);

        // Streaming across pointer wrap.
        repeat (10) step(1'b1, rand_instr(), 1'b1, 1'b0);
        drain();

        // Simultaneous push and pop at occupancy 2.
        repeat (2) step(1'b1, rand_instr(), 1'b0, 1'b0);
        step(1'b1, rand_instr(), 1'b1, 1'b0);
        idle(1'b0);
        drain();

        // Flush at occupancy 3 with push and pop active.
        repeat (3) step(1'b1, rand_instr(), 1'b0, 1'b0);
        step(1'b1, rand_instr(), 1'b1, 1'b1);
        idle(1'b0);
        step(1'b1, rand_instr(), 1'b0, 1'b0);
        drain();

        // Push while empty, with and without a same-cycle pop.
        step(1'b1, rand_instr(), 1'b1, 1'b0);
        idle(1'b0);
        step(1'b1, rand_instr(), 1'b0, 1'b0);
        idle(1'b0);
        drain();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            step($urandom_range(0, 99) < 60, rand_instr(), $urandom_range(0, 99) < 50, r < 4);
        end
        drain();

        // Asynchronous reset mid-stream at occupancy 3.
        repeat (3) step(1'b1, rand_instr(), 1'b0, 1'b0);
        @(posedge clk);
        #2;
        push_valid = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        rst        = 1'b1;
        #1;
        check("midrst_valid", 64'(valid_out), 64'(0));
        check("midrst_occ", 64'(occupancy), 64'(0));
        check("midrst_ready", 64'(push_ready), 64'(1));
        sb.delete();
        model_cnt = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        step(1'b1, rand_instr(), 1'b0, 1'b0);
        step(1'b1, rand_instr(), 1'b0, 1'b0);
        drain();
        idle(1'b0);

        @(posedge clk);
        #8;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
